stack_control: RTL and testbench

STACK_CONTROL -- requirements
Module: stack_control

---
 rtl/stack_control.sv | 131 +++++++++++++
 tb/tb_stack_control.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stack_control.sv
// Four-entry LIFO controller with thermometer occupancy and change pulse.
// Define STACK_ERR_EN to add the sticky err flag and the ERROR lock-up state.
module stack_control #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        enable,
    output logic              checkupdate,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 3;

`ifdef STACK_ERR_EN
    typedef enum logic [1:0] {S_EMPTY, S_LOADED, S_FULL, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_EMPTY, S_LOADED, S_FULL} state_t;
`endif

    state_t            r_state;
    logic [3:0]        r_enable;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_checkupdate;

    logic [CNT_W-1:0]  w_count;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_push_only;
    logic              w_pop_only;
    logic              w_replace;
    logic              w_locked;

    // Occupancy decode; push+pop while empty degrades to a plain push.
    assign w_count     = CNT_W'(r_enable[0]) + CNT_W'(r_enable[1])
                       + CNT_W'(r_enable[2]) + CNT_W'(r_enable[3]);
    assign w_top_idx   = IDX_W'(w_count - CNT_W'(1));
    assign w_push_only = push && (!pop || empty);
    assign w_pop_only  = pop && !push;
    assign w_replace   = push && pop && !empty;

`ifdef STACK_ERR_EN
    logic r_err;
    assign w_locked = (r_state == S_ERROR);
    assign err      = r_err;
`else
    assign w_locked = 1'b0;
    assign err      = 1'b0;
`endif

    assign enable      = r_enable;
    assign checkupdate = r_checkupdate;
    assign full        = (r_enable == 4'b1111);
    assign empty       = (r_enable == 4'b0000);
    assign data_out    = empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_EMPTY;
            r_enable      <= '0;
            r_checkupdate <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
`ifdef STACK_ERR_EN
            r_err         <= 1'b0;
`endif
        end else begin
            r_checkupdate <= 1'b0;

            // Datapath: illegal requests fall through every branch untouched.
            if (!w_locked) begin
                if (w_push_only && !full) begin
                    r_mem[IDX_W'(w_count)] <= data_in;
                    r_enable               <= {r_enable[2:0], 1'b1};
                    r_checkupdate          <= 1'b1;
                end else if (w_pop_only && !empty) begin
                    r_mem[w_top_idx] <= '0;
                    r_enable         <= {1'b0, r_enable[3:1]};
                    r_checkupdate    <= 1'b1;
                end else if (w_replace) begin
                    r_mem[w_top_idx] <= data_in;
                end
            end

            case (r_state)
                S_EMPTY: begin
                    if (push) begin
                        r_state <= S_LOADED;
                    end
`ifdef STACK_ERR_EN
                    else if (pop) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end
`endif
                end
                S_LOADED: begin
                    if (w_push_only && (w_count == CNT_W'(3))) begin
                        r_state <= S_FULL;
                    end else if (w_pop_only && (w_count == CNT_W'(1))) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop_only) begin
                        r_state <= S_LOADED;
                    end
`ifdef STACK_ERR_EN
                    else if (w_push_only) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end
`endif
                end
`ifdef STACK_ERR_EN
                S_ERROR: r_state <= S_ERROR;
`endif
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_control.sv
// Scoreboard bench for stack_control: driver queues expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_stack_control;

`ifdef STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       push    = 1'b0;
    logic       pop     = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [3:0] data_out;
    logic [3:0] enable;
    logic       checkupdate;
    logic       full;
    logic       empty;
    logic       err;

    typedef struct {
        int         cyc;
        string      nm;
        logic [11:0] v;
    } exp_item_t;

    exp_item_t  sb[$];
    exp_item_t  m_it;
    logic [11:0] m_act;
    int         cyc     = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    stack_control #(.DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .data_out   (data_out),
        .enable     (enable),
        .checkupdate(checkupdate),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation that targets the edge just taken.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            m_it  = sb.pop_front();
            m_act = {enable, data_out, checkupdate, full, empty, err};
            n_tests++;
            if (m_act !== m_it.v) begin
                n_fail++;
                $display("FAIL %s: got en=%b dout=%h cu=%b full=%b empty=%b err=%b, want en=%b dout=%h cu=%b full=%b empty=%b err=%b",
                         m_it.nm, m_act[11:8], m_act[7:4], m_act[3], m_act[2], m_act[1], m_act[0],
                         m_it.v[11:8], m_it.v[7:4], m_it.v[3], m_it.v[2], m_it.v[1], m_it.v[0]);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic p, input logic o,
                        input logic [3:0] d, input logic [3:0] en, input logic [3:0] dout,
                        input logic cu, input logic er);
        exp_item_t it;
        @(negedge clk);
        reset   = r;
        push    = p;
        pop     = o;
        data_in = d;
        it.cyc  = cyc + 1;
        it.nm   = nm;
        it.v    = {en, dout, cu, (en == 4'hF), (en == 4'h0), er};
        sb.push_back(it);
    endtask

    initial begin
        //    name            rst psh pop din   en     dout cu  err
        step("reset",         1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        step("reset_push",    1, 1, 0, 4'h7, 4'h0, 4'h0, 0, 0);
        // Fill to full
        step("push_3",        0, 1, 0, 4'h3, 4'h1, 4'h3, 1, 0);
        step("push_5",        0, 1, 0, 4'h5, 4'h3, 4'h5, 1, 0);
        step("push_9",        0, 1, 0, 4'h9, 4'h7, 4'h9, 1, 0);
        step("push_C",        0, 1, 0, 4'hC, 4'hF, 4'hC, 1, 0);
        step("idle_full",     0, 0, 0, 4'h0, 4'hF, 4'hC, 0, 0);
        // Drain to empty
        step("pop_1",         0, 0, 1, 4'h0, 4'h7, 4'h9, 1, 0);
        step("pop_2",         0, 0, 1, 4'h0, 4'h3, 4'h5, 1, 0);
        step("pop_3",         0, 0, 1, 4'h0, 4'h1, 4'h3, 1, 0);
        step("pop_4",         0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0);
        step("idle_empty",    0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        // Replace top with two entries
        step("push_3b",       0, 1, 0, 4'h3, 4'h1, 4'h3, 1, 0);
        step("push_5b",       0, 1, 0, 4'h5, 4'h3, 4'h5, 1, 0);
        step("replace_A",     0, 1, 1, 4'hA, 4'h3, 4'hA, 0, 0);
        step("pop_after_rep", 0, 0, 1, 4'h0, 4'h1, 4'h3, 1, 0);
        step("pop_to_empty",  0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0);
        // Push+pop while empty acts as push; replace while full is legal
        step("pushpop_empty", 0, 1, 1, 4'h6, 4'h1, 4'h6, 1, 0);
        step("push_1",        0, 1, 0, 4'h1, 4'h3, 4'h1, 1, 0);
        step("push_2",        0, 1, 0, 4'h2, 4'h7, 4'h2, 1, 0);
        step("push_4",        0, 1, 0, 4'h4, 4'hF, 4'h4, 1, 0);
        step("replace_full",  0, 1, 1, 4'hE, 4'hF, 4'hE, 0, 0);
        // Push while full is illegal
        step("push_on_full",  0, 1, 0, 4'hF, 4'hF, 4'hE, 0, ERR);
        step("pop_after_ill", 0, 0, 1, 4'h0, ERR ? 4'hF : 4'h7, ERR ? 4'hE : 4'h2, !ERR, ERR);
        step("reset_2",       1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        // Pop while empty is illegal
        step("pop_on_empty",  0, 0, 1, 4'h0, 4'h0, 4'h0, 0, ERR);
        step("push_after_pe", 0, 1, 0, 4'h8, ERR ? 4'h0 : 4'h1, ERR ? 4'h0 : 4'h8, !ERR, ERR);
        step("reset_3",       1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        // Reset beats push mid-operation
        step("push_1c",       0, 1, 0, 4'h1, 4'h1, 4'h1, 1, 0);
        step("push_2c",       0, 1, 0, 4'h2, 4'h3, 4'h2, 1, 0);
        step("push_3c",       0, 1, 0, 4'h3, 4'h7, 4'h3, 1, 0);
        step("reset_w_push",  1, 1, 0, 4'h5, 4'h0, 4'h0, 0, 0);
        step("idle_post_rst", 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        step("push_after_rst",0, 1, 0, 4'h5, 4'h1, 4'h5, 1, 0);
        step("idle_end",      0, 0, 0, 4'h0, 4'h1, 4'h5, 0, 0);

        repeat (4) @(negedge clk);
        while (sb.size() > 0) begin
            m_it = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared (target cycle %0d, now %0d)", m_it.nm, m_it.cyc, cyc);
        end

        // Final hold state after idle cycles.
        n_tests++;
        if (enable !== 4'h1) begin
            n_fail++;
            $display("FAIL final_enable: got %b want 0001", enable);
        end
        n_tests++;
        if (data_out !== 4'h5) begin
            n_fail++;
            $display("FAIL final_data_out: got %h want 5", data_out);
        end
        n_tests++;
        if (checkupdate !== 1'b0) begin
            n_fail++;
            $display("FAIL final_checkupdate: got %b want 0", checkupdate);
        end
        n_tests++;
        if (full !== 1'b0) begin
            n_fail++;
            $display("FAIL final_full: got %b want 0", full);
        end
        n_tests++;
        if (empty !== 1'b0) begin
            n_fail++;
            $display("FAIL final_empty: got %b want 0", empty);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL final_err: got %b want 0", err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
